// File: rtl/exec_unit_if.sv
// Execute-stage bus: instruction fields in, registered results out.
// The master drives the instruction; the slave (exec_unit) returns results.
interface exec_unit_if;
    logic        i_valid;
    logic [3:0]  i_opcode;
    logic [2:0]  i_alu_op;
    logic        i_alu_src;
    logic [1:0]  i_imm_sel;
    logic        i_branch;
    logic [35:0] i_rs1_data;
    logic [35:0] i_rs2_data;
    logic [13:0] i_imm_raw;
    logic [13:0] i_pc;
    logic        o_valid;
    logic [35:0] o_alu_result;
    logic        o_zero;
    logic        o_negative;
    logic        o_carry;
    logic        o_overflow;
    logic [35:0] o_imm_ext;
    logic [35:0] o_store_data;
    logic        o_branch_taken;
    logic [13:0] o_next_pc;

    modport master (
        output i_valid, i_opcode, i_alu_op, i_alu_src, i_imm_sel,
        output i_branch, i_rs1_data, i_rs2_data, i_imm_raw, i_pc,
        input  o_valid, o_alu_result, o_zero, o_negative, o_carry,
        input  o_overflow, o_imm_ext, o_store_data, o_branch_taken,
        input  o_next_pc
    );

    modport slave (
        input  i_valid, i_opcode, i_alu_op, i_alu_src, i_imm_sel,
        input  i_branch, i_rs1_data, i_rs2_data, i_imm_raw, i_pc,
        output o_valid, o_alu_result, o_zero, o_negative, o_carry,
        output o_overflow, o_imm_ext, o_store_data, o_branch_taken,
        output o_next_pc
    );
endinterface

// File: rtl/exec_unit.sv
// 36-bit execute stage: imm extend, ALU, flags, branch resolve, 1-cycle latency.
// Define EXEC_CARRY_FLAGS_EN to enable carry/overflow flags and CS/VS branches.
module exec_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    exec_unit_if.slave  bus
);
`ifdef EXEC_CARRY_FLAGS_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    logic [35:0] op_a;
    logic [35:0] op_b;
    logic [35:0] imm_ext;
    logic [36:0] sum;
    logic [35:0] result;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic        cond;
    logic        taken;
    logic [5:0]  shamt;
    logic        big_shift;
    logic [13:0] br_off;
    logic [13:0] next_pc;

    assign op_a = bus.i_rs1_data;

    always_comb begin
        imm_ext = '0;
        unique case (bus.i_imm_sel)
            2'b00: imm_ext = {22'd0, bus.i_imm_raw};
            2'b01: imm_ext = {{22{bus.i_imm_raw[13]}}, bus.i_imm_raw};
            2'b10: imm_ext = {{28{bus.i_imm_raw[7]}}, bus.i_imm_raw[7:0]};
            2'b11: imm_ext = {bus.i_imm_raw, 22'd0};
        endcase
    end

    assign op_b      = bus.i_alu_src ? imm_ext : bus.i_rs2_data;
    assign shamt     = op_b[5:0];
    assign big_shift = shamt >= 6'd36;

    // SUB carry is the inverted borrow: A + ~B + 1
    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (bus.i_alu_op)
            3'b000: begin
                sum    = {1'b0, op_a} + {1'b0, op_b};
                result = sum[35:0];
                carry  = sum[36];
                ovf    = (op_a[35] == op_b[35]) && (result[35] != op_a[35]);
            end
            3'b001: begin
                sum    = {1'b0, op_a} + {1'b0, ~op_b} + 37'd1;
                result = sum[35:0];
                carry  = sum[36];
                ovf    = (op_a[35] != op_b[35]) && (result[35] != op_a[35]);
            end
            3'b010: result = op_a & op_b;
            3'b011: result = op_a | op_b;
            3'b100: result = op_a ^ op_b;
            3'b101: result = big_shift ? '0 : op_a << shamt;
            3'b110: result = big_shift ? '0 : op_a >> shamt;
            3'b111: result = big_shift ? {36{op_a[35]}}
                                       : 36'($signed(op_a) >>> shamt);
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[35];

    always_comb begin
        cond = 1'b0;
        case (bus.i_opcode)
            4'b1000: cond = 1'b1;
            4'b1001: cond = zero;
            4'b1010: cond = !zero;
            4'b1011: cond = neg;
            4'b1100: cond = !neg;
            4'b1101: cond = CARRY_EN && carry;
            4'b1110: cond = CARRY_EN && ovf;
            default: cond = 1'b0;
        endcase
    end

    assign taken   = bus.i_branch && cond && bus.i_valid;
    assign br_off  = {{6{bus.i_imm_raw[7]}}, bus.i_imm_raw[7:0]};
    assign next_pc = taken ? bus.i_pc + br_off : bus.i_pc + 14'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_valid        <= 1'b0;
            bus.o_alu_result   <= '0;
            bus.o_zero         <= 1'b0;
            bus.o_negative     <= 1'b0;
            bus.o_carry        <= 1'b0;
            bus.o_overflow     <= 1'b0;
            bus.o_imm_ext      <= '0;
            bus.o_store_data   <= '0;
            bus.o_branch_taken <= 1'b0;
            bus.o_next_pc      <= 14'h2000;
        end else if (bus.i_valid) begin
            bus.o_valid        <= 1'b1;
            bus.o_alu_result   <= result;
            bus.o_zero         <= zero;
            bus.o_negative     <= neg;
            bus.o_carry        <= CARRY_EN && carry;
            bus.o_overflow     <= CARRY_EN && ovf;
            bus.o_imm_ext      <= imm_ext;
            bus.o_store_data   <= bus.i_rs2_data;
            bus.o_branch_taken <= taken;
            bus.o_next_pc      <= next_pc;
        end else begin
            bus.o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed cases plus random traffic
// checked against an arithmetic reference model.
module tb_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_seen = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;

    exec_unit_if bus ();

    exec_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [35:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic [35:0] imm;
        logic [35:0] st;
        logic        tk;
        logic [13:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t last;

    localparam longint M = 64'h10_0000_0000;

    function automatic longint sgn(input longint x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    function automatic exp_t model(
        input logic [3:0]  opc,
        input logic [2:0]  aop,
        input logic        src,
        input logic [1:0]  sel,
        input logic        br,
        input logic [35:0] rs1,
        input logic [35:0] rs2,
        input logic [13:0] imm,
        input logic [13:0] pc
    );
        exp_t   e;
        longint a, b, ie, s, t, r, sh;
        int     im, b8, off, p;
        bit     c, v, z, n, cond;
        a  = longint'(rs1);
        im = int'(imm);
        c  = 0;
        v  = 0;
        r  = 0;
        case (sel)
            2'd0: ie = im;
            2'd1: ie = (im >= 8192) ? im + M - 16384 : im;
            2'd2: begin
                b8 = im % 256;
                ie = (b8 >= 128) ? b8 + M - 256 : b8;
            end
            default: ie = longint'(im) * 4194304;
        endcase
        b  = src ? ie : longint'(rs2);
        sh = b % 64;
        case (aop)
            3'd0: begin
                s = a + b;
                r = s % M;
                c = s >= M;
                t = sgn(a) + sgn(b);
                v = (t >= M / 2) || (t < -(M / 2));
            end
            3'd1: begin
                s = a + (M - 1 - b) + 1;
                r = s % M;
                c = s >= M;
                t = sgn(a) - sgn(b);
                v = (t >= M / 2) || (t < -(M / 2));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sh >= 36) ? 0 : (a << sh) & (M - 1);
            3'd6: r = (sh >= 36) ? 0 : a >> sh;
            default: begin
                if (sh >= 36) r = (sgn(a) < 0) ? M - 1 : 0;
                else begin
                    t = sgn(a) >>> sh;
                    r = (t < 0) ? t + M : t;
                end
            end
        endcase
        z = (r == 0);
        n = (r >= M / 2);
`ifndef EXEC_CARRY_FLAGS_EN
        c = 0;
        v = 0;
`endif
        case (opc)
            4'd8:  cond = 1;
            4'd9:  cond = z;
            4'd10: cond = !z;
            4'd11: cond = n;
            4'd12: cond = !n;
            4'd13: cond = c;
            4'd14: cond = v;
            default: cond = 0;
        endcase
        off = im % 256;
        off = (off >= 128) ? off - 256 : off;
        p   = int'(pc);
        e.res = r[35:0];
        e.z   = z;
        e.n   = n;
        e.c   = c;
        e.v   = v;
        e.imm = ie[35:0];
        e.st  = rs2;
        e.tk  = br && cond;
        e.pc  = (br && cond) ? 14'((p + off + 16384) % 16384)
                             : 14'((p + 1) % 16384);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, ".result"}, 64'(bus.o_alu_result), 64'(e.res));
        chk({tag, ".zero"}, 64'(bus.o_zero), 64'(e.z));
        chk({tag, ".neg"}, 64'(bus.o_negative), 64'(e.n));
        chk({tag, ".carry"}, 64'(bus.o_carry), 64'(e.c));
        chk({tag, ".ovf"}, 64'(bus.o_overflow), 64'(e.v));
        chk({tag, ".imm"}, 64'(bus.o_imm_ext), 64'(e.imm));
        chk({tag, ".store"}, 64'(bus.o_store_data), 64'(e.st));
        chk({tag, ".taken"}, 64'(bus.o_branch_taken), 64'(e.tk));
        chk({tag, ".next_pc"}, 64'(bus.o_next_pc), 64'(e.pc));
    endtask

    always @(posedge clk) rst_seen <= rst;

    // Monitor: reset image, popped transactions, or held values.
    always @(negedge clk) begin
        exp_t rv;
        rv    = '0;
        rv.pc = 14'h2000;
        if (rst_seen) begin
            chk("rst.valid", 64'(bus.o_valid), 64'd0);
            cmp_out("rst", rv);
            last  = rv;
            armed = 1'b1;
        end else if (armed && bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb.underflow", 64'd1, 64'd0);
            end else begin
                last = sb.pop_front();
                cmp_out("txn", last);
            end
        end else if (armed) begin
            chk("hold.valid", 64'(bus.o_valid), 64'd0);
            cmp_out("hold", last);
        end
    end

    task automatic issue(
        input logic        vld,
        input logic [3:0]  opc,
        input logic [2:0]  aop,
        input logic        src,
        input logic [1:0]  sel,
        input logic        br,
        input logic [35:0] rs1,
        input logic [35:0] rs2,
        input logic [13:0] imm,
        input logic [13:0] pc,
        input logic        in_rst
    );
        @(posedge clk);
        #1;
        rst            = in_rst;
        bus.i_valid    = vld;
        bus.i_opcode   = opc;
        bus.i_alu_op   = aop;
        bus.i_alu_src  = src;
        bus.i_imm_sel  = sel;
        bus.i_branch   = br;
        bus.i_rs1_data = rs1;
        bus.i_rs2_data = rs2;
        bus.i_imm_raw  = imm;
        bus.i_pc       = pc;
        if (vld && !in_rst)
            sb.push_back(model(opc, aop, src, sel, br, rs1, rs2, imm, pc));
    endtask

    function automatic logic [35:0] r36();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        return x[35:0];
    endfunction

    task automatic rand_issue(input logic in_rst);
        logic [35:0] a, b;
        logic [3:0]  opc;
        a   = r36();
        b   = ($urandom_range(0, 3) == 0) ? a : r36();
        if ($urandom_range(0, 2) == 0) b = 36'($urandom_range(0, 63));
        if ($urandom_range(0, 5) == 0) a = 36'h7_FFFF_FFFF + 36'($urandom_range(0, 2));
        opc = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'($urandom_range(8, 14));
        issue(1'($urandom_range(0, 3) != 0), opc, 3'($urandom()),
              1'($urandom()), 2'($urandom()), 1'($urandom()), a, b,
              14'($urandom()), 14'($urandom()), in_rst);
    endtask

    initial begin
        bus.i_valid    = 1'b0;
        bus.i_opcode   = '0;
        bus.i_alu_op   = '0;
        bus.i_alu_src  = 1'b0;
        bus.i_imm_sel  = '0;
        bus.i_branch   = 1'b0;
        bus.i_rs1_data = '0;
        bus.i_rs2_data = '0;
        bus.i_imm_raw  = '0;
        bus.i_pc       = '0;
        // ADD immediate, sign-extended -1
        issue(1, 4'h0, 3'd0, 1, 2'b01, 0, 36'd5, 36'd0, 14'h3FFF, 14'h0100, 0);
        // BEQ taken backwards
        issue(1, 4'h9, 3'd1, 0, 2'b00, 1, 36'h123, 36'h123, 14'h00FE, 14'h2005, 0);
        // BNE not taken, PC wraps
        issue(1, 4'hA, 3'd1, 0, 2'b00, 1, 36'h77, 36'h77, 14'h0010, 14'h3FFF, 0);
        issue(1, 4'h0, 3'd7, 0, 2'b00, 0, 36'h8_0000_0000, 36'd4, 14'h0, 14'h0, 0);
        issue(1, 4'h0, 3'd6, 0, 2'b00, 0, 36'hF_1234_5678, 36'd40, 14'h0, 14'h0, 0);
        issue(0, 4'h0, 3'd0, 0, 2'b00, 0, 36'h1, 36'h1, 14'h0, 14'h0, 0);
        // ADD carry-out to zero
        issue(1, 4'hD, 3'd0, 0, 2'b00, 1, 36'hF_FFFF_FFFF, 36'd1, 14'h0004, 14'h0040, 0);
        issue(1, 4'hE, 3'd0, 0, 2'b00, 1, 36'h7_FFFF_FFFF, 36'd1, 14'h0008, 14'h0050, 0);
        issue(1, 4'h8, 3'd2, 1, 2'b11, 1, 36'hF_FFFF_FFFF, 36'd0, 14'h2A80, 14'h0000, 0);
        issue(1, 4'hB, 3'd5, 1, 2'b10, 1, 36'h0_0000_0003, 36'd0, 14'h0022, 14'h1000, 0);
        // reset with a valid instruction: must be discarded
        issue(1, 4'h8, 3'd0, 0, 2'b00, 1, 36'h5, 36'h6, 14'h0, 14'h0123, 1);
        for (int i = 0; i < 400; i++)
            rand_issue(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        issue(0, 4'h0, 3'd0, 0, 2'b00, 0, 36'h0, 36'h0, 14'h0, 14'h0, 0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("sb.drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports i_clk and i_rst.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  instruction present this cycle.
- i_opcode  in  4  instruction opcode, used for the branch condition.
- i_alu_op  in  3  ALU operation select.
- i_alu_src  in  1  operand B select: 0 = i_rs2_data, 1 = extended immediate.
- i_imm_sel  in  2  immediate format select.
- i_branch  in  1  instruction is a branch.
- i_rs1_data  in  36  operand A.
- i_rs2_data  in  36  register operand B.
- i_imm_raw  in  14  raw immediate, instruction bits [13:0].
- i_pc  in  14  PC of the current instruction.
- o_valid  out  1  registered i_valid.
- o_alu_result  out  36  registered ALU result.
- o_zero, o_negative  out  1 each  registered result flags.
- o_carry, o_overflow  out  1 each  registered carry and overflow flags.
- o_imm_ext  out  36  registered extended immediate.
- o_store_data  out  36  registered i_rs2_data.
- o_branch_taken  out  1  registered branch decision.
- o_next_pc  out  14  registered next PC.
REQ-003 Widths SHALL be fixed: data 36, PC 14, immediate 14, opcode 4.

Function
REQ-004 All outputs SHALL be registered on the rising edge of i_clk, giving exactly 1 cycle latency from inputs to outputs.
REQ-005 When i_valid=0, o_valid SHALL become 0 and all other outputs SHALL hold their previous values.
REQ-006 Immediate extension SHALL depend on i_imm_sel:
- 00: zero-extend imm[13:0].
- 01: sign-extend imm[13:0].
- 10: sign-extend imm[7:0].
- 11: place imm[13:0] in bits [35:22], with the low 22 bits = 0.
REQ-007 Operand B SHALL be i_rs2_data when i_alu_src=0 and the extended immediate when i_alu_src=1.
REQ-008 ALU operations SHALL be selected by i_alu_op:
- 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR.
- 101 SLL, 110 SRL, 111 SRA.
- All arithmetic is modulo 2^36.
REQ-009 Shifts SHALL use B[5:0] as the shift amount; an amount of 36 or more SHALL give 0 for SLL/SRL and all-sign-bit for SRA.
REQ-010 Flags SHALL be defined as follows:
- zero = (result==0).
- negative = result[35].
- Both flags are valid for every operation.
REQ-011 The branch condition SHALL be decoded from i_opcode:
- 1000 always.
- 1001 EQ (zero).
- 1010 NE (!zero).
- 1011 LT (negative).
- 1100 GE (!negative).
- Any other opcode: condition false.
- The condition is evaluated on the same-cycle combinational ALU flags.
REQ-012 Branch taken SHALL equal i_branch AND condition AND i_valid.
REQ-013 The branch target SHALL be i_pc + sign-extended imm[7:0], modulo 2^14.
REQ-014 next_pc SHALL be the branch target when taken, otherwise i_pc+1, modulo 2^14; 0x3FFF+1 wraps to 0x0000.

Reset
REQ-015 While i_rst=1 at a clock edge, the block SHALL set:
- o_valid = 0
- o_branch_taken = 0
- all data outputs and flags = 0
- o_next_pc = 14'h2000
REQ-016 Reset SHALL take priority over i_valid; any instruction presented during a reset cycle SHALL be discarded.

Configuration
REQ-017 Macro EXEC_CARRY_FLAGS_EN SHALL compile carry and overflow support in or out.
- Defined:
  - ADD carry = bit 36 of A+B.
  - SUB carry = bit 36 of A+~B+1 (1 = no borrow).
  - overflow = signed overflow of ADD/SUB.
  - For logic and shift operations, carry = 0 and overflow = 0.
  - Opcodes 1101 (CS, carry) and 1110 (VS, overflow) are valid branch conditions.
- Undefined:
  - o_carry and o_overflow are tied to 0.
  - Opcodes 1101 and 1110 are never-taken conditions.

Verification
REQ-018 The bench SHALL cover at least these scenarios:
- Reset: hold i_rst=1 for 1 cycle -> o_valid=0, o_alu_result=0, o_next_pc=0x2000.
- ADD immediate: rs1=5, imm_raw=0x3FFF, imm_sel=01, alu_src=1, op 000 -> next cycle result=4, zero=0, negative=0, o_imm_ext=0xFFFFFFFFF.
- BEQ: rs1=rs2=0x123, op SUB, opcode 1001, branch=1, pc=0x2005, imm[7:0]=0xFE -> zero=1, taken=1, next_pc=0x2003.
- BNE not taken with wrap: rs1=rs2, opcode 1010, pc=0x3FFF -> taken=0, next_pc=0x0000.
- SRA: rs1=0x800000000, rs2=4, op 111 -> result=0xF80000000, negative=1; SRL by 40 -> result=0.
- Carry flags: ADD 0xFFFFFFFFF+1 -> result=0, zero=1; carry=1 with EXEC_CARRY_FLAGS_EN defined, carry=0 without.
